// File: rtl/adc_permit_pkg.sv
// adc_permit_pkg: shared types and helpers for the multi-channel ADC feedback permit.
//   ch_state_e  per-channel health state (ok / pending fault / fault / recovering)
//   win_check   inclusive window compare with a symmetric margin that never wraps
package adc_permit_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PEND    = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } ch_state_e;

  // Operands are zero-extended to CmpW bits so lo+margin cannot overflow for any W below 32.
  localparam int unsigned CmpW = 32;

  // True when lo+margin <= val <= hi-margin. A margin larger than hi leaves an empty window
  // instead of wrapping, so recovery is simply impossible for such settings.
  function automatic logic win_check(input logic [CmpW-1:0] val,
                                     input logic [CmpW-1:0] lo,
                                     input logic [CmpW-1:0] hi,
                                     input logic [CmpW-1:0] margin);
    logic [CmpW-1:0] lo_m;
    logic [CmpW-1:0] hi_m;
    if (margin > hi) begin
      return 1'b0;
    end
    lo_m = lo + margin;
    hi_m = hi - margin;
    return (val >= lo_m) && (val <= hi_m);
  endfunction

endpackage

// File: rtl/adc_permit_ch.sv
// adc_permit_ch: health tracking for one ADC channel.
//   clk_i, sclr_i   clock and synchronous active-high reset
//   flt_valid_i     filtered sample for this channel is present on flt_i this cycle
//   flt_i           filtered sample value
//   low_i, high_i   window bounds for this channel
//   hyst_i          hysteresis margin used while recovering from a fault
//   adc_err_i       ADC interface error, forces fault
//   accept_i        raw sample accepted for this channel this cycle (reloads timeout)
//   ena_i           channel enable; timeout counter is held at zero while low
//   ok_o            channel healthy (ok or only pending a fault)
module adc_permit_ch
  import adc_permit_pkg::*;
#(
  parameter int unsigned W       = 10,
  parameter int unsigned HOLD    = 3,
  parameter int unsigned RECOVER = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic         clk_i,
  input  logic         sclr_i,
  input  logic         flt_valid_i,
  input  logic [W-1:0] flt_i,
  input  logic [W-1:0] low_i,
  input  logic [W-1:0] high_i,
  input  logic [W-1:0] hyst_i,
  input  logic         adc_err_i,
  input  logic         accept_i,
  input  logic         ena_i,
  output logic         ok_o
);

  localparam int unsigned DbMax = (HOLD > RECOVER) ? HOLD : RECOVER;
  localparam int unsigned DbW   = $clog2(DbMax + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  ch_state_e       state_q, state_d;
  logic [DbW-1:0]  cnt_q, cnt_d;
  logic [DbW-1:0]  cnt_inc;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_expire;
  logic            in_win;
  logic            in_hyst;

  assign in_win  = win_check(CmpW'(flt_i), CmpW'(low_i), CmpW'(high_i), '0);
  assign in_hyst = win_check(CmpW'(flt_i), CmpW'(low_i), CmpW'(high_i), CmpW'(hyst_i));
  assign cnt_inc = cnt_q + 1'b1;

  // Timeout counter saturates at TIMEOUT so a stale channel keeps being forced to fault.
  always_comb begin
    tmo_d = tmo_q;
    if (accept_i || !ena_i) begin
      tmo_d = '0;
    end else if (32'(tmo_q) < TIMEOUT) begin
      tmo_d = tmo_q + 1'b1;
    end
    tmo_expire = (32'(tmo_d) >= TIMEOUT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (adc_err_i || tmo_expire) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else if (flt_valid_i) begin
      unique case (state_q)
        ST_OK: begin
          if (!in_win) begin
            if (HOLD <= 1) begin
              state_d = ST_FAULT;
              cnt_d   = '0;
            end else begin
              state_d = ST_PEND;
              cnt_d   = DbW'(1);
            end
          end
        end
        ST_PEND: begin
          if (!in_win) begin
            if (32'(cnt_inc) >= HOLD) begin
              state_d = ST_FAULT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_OK;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          if (in_hyst) begin
            if (RECOVER <= 1) begin
              state_d = ST_OK;
              cnt_d   = '0;
            end else begin
              state_d = ST_RECOVER;
              cnt_d   = DbW'(1);
            end
          end
        end
        ST_RECOVER: begin
          if (in_hyst) begin
            if (32'(cnt_inc) >= RECOVER) begin
              state_d = ST_OK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      state_q <= ST_FAULT;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ok_o = (state_q == ST_OK) || (state_q == ST_PEND);

endmodule

// File: rtl/adc_permit_mc.sv
// adc_permit_mc: multi-channel ADC feedback permit.
// Averages time-multiplexed ADC samples per channel, checks each average against a per-channel
// window with hysteresis and debounce, watches for stale channels, and drives a registered permit.
//   clk, sclr              clock and synchronous active-high reset
//   adc, adc_ch, adc_valid sample value, channel index and strobe
//   adc_err                ADC interface error
//   low, high              per-channel window bounds, channel i at [i*W +: W]
//   hyst                   shared hysteresis margin
//   fb_ena                 channel enables (disabled channels do not affect permit)
//   soft_permit            software permit
//   oi, fault_clr          operator interrupt (latched) and its clear
//   flt_adc, flt_ch        last filtered sample and its channel
//   flt_valid              one-cycle strobe for a new filtered sample
//   ch_ok                  per-channel healthy flags
//   permit                 overall permit
module adc_permit_mc
  import adc_permit_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned W        = 10,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned HOLD     = 3,
  parameter int unsigned RECOVER  = 4,
  parameter int unsigned TIMEOUT  = 1000,
  localparam int unsigned CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic [W-1:0]    adc,
  input  logic [CHW-1:0]  adc_ch,
  input  logic            adc_valid,
  input  logic            adc_err,
  input  logic [CH*W-1:0] low,
  input  logic [CH*W-1:0] high,
  input  logic [W-1:0]    hyst,
  input  logic [CH-1:0]   fb_ena,
  input  logic            soft_permit,
  input  logic            oi,
  input  logic            fault_clr,
  output logic [W-1:0]    flt_adc,
  output logic [CHW-1:0]  flt_ch,
  output logic            flt_valid,
  output logic [CH-1:0]   ch_ok,
  output logic            permit
);

  localparam int unsigned AccW  = W + AVG_LOG2;
  localparam int unsigned NW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned NLast = (1 << AVG_LOG2) - 1;

  logic [AccW-1:0] acc_q [CH];
  logic [AccW-1:0] acc_d [CH];
  logic [NW-1:0]   n_q   [CH];
  logic [NW-1:0]   n_d   [CH];
  logic [AccW-1:0] sum;

  logic [W-1:0]    flt_adc_q, flt_adc_d;
  logic [CHW-1:0]  flt_ch_q, flt_ch_d;
  logic            flt_valid_q, flt_valid_d;
  logic            oi_q, oi_d;
  logic            permit_q, permit_d;
  logic            accept;
  logic [CH-1:0]   ch_accept;
  logic [CH-1:0]   ch_flt_valid;
  logic [CH-1:0]   ch_ok_w;

  // Out-of-range channel indices never match any i, so those samples are dropped.
  assign accept = adc_valid & ~adc_err;

  always_comb begin
    acc_d       = acc_q;
    n_d         = n_q;
    flt_adc_d   = flt_adc_q;
    flt_ch_d    = flt_ch_q;
    flt_valid_d = 1'b0;
    sum         = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (adc_valid && (32'(adc_ch) == i)) begin
        if (adc_err) begin
          acc_d[i] = '0;
          n_d[i]   = '0;
        end else begin
          sum = acc_q[i] + AccW'(adc);
          if (32'(n_q[i]) == NLast) begin
            flt_adc_d   = W'(sum >> AVG_LOG2);
            flt_ch_d    = adc_ch;
            flt_valid_d = 1'b1;
            acc_d[i]    = '0;
            n_d[i]      = '0;
          end else begin
            acc_d[i] = sum;
            n_d[i]   = n_q[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign ch_accept[g]    = accept && (32'(adc_ch) == g);
    assign ch_flt_valid[g] = flt_valid_q && (32'(flt_ch_q) == g);

    adc_permit_ch #(
      .W       (W),
      .HOLD    (HOLD),
      .RECOVER (RECOVER),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk_i       (clk),
      .sclr_i      (sclr),
      .flt_valid_i (ch_flt_valid[g]),
      .flt_i       (flt_adc_q),
      .low_i       (low[g*W +: W]),
      .high_i      (high[g*W +: W]),
      .hyst_i      (hyst),
      .adc_err_i   (adc_err),
      .accept_i    (ch_accept[g]),
      .ena_i       (fb_ena[g]),
      .ok_o        (ch_ok_w[g])
    );
  end

  // A simultaneous oi keeps the latch set even when fault_clr is asserted.
  always_comb begin
    oi_d     = oi | (oi_q & ~fault_clr);
    permit_d = soft_permit & ~oi_q & (&(ch_ok_w | ~fb_ena));
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
        n_q[i]   <= '0;
      end
      flt_adc_q   <= '0;
      flt_ch_q    <= '0;
      flt_valid_q <= 1'b0;
      oi_q        <= 1'b0;
      permit_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      n_q         <= n_d;
      flt_adc_q   <= flt_adc_d;
      flt_ch_q    <= flt_ch_d;
      flt_valid_q <= flt_valid_d;
      oi_q        <= oi_d;
      permit_q    <= permit_d;
    end
  end

  assign flt_adc   = flt_adc_q;
  assign flt_ch    = flt_ch_q;
  assign flt_valid = flt_valid_q;
  assign ch_ok     = ch_ok_w;
  assign permit    = permit_q;

endmodule

// File: tb/tb_adc_permit_mc.sv
// tb_adc_permit_mc: directed scenarios plus randomized traffic for adc_permit_mc, checked against
// a cycle-stepped behavioural model built from running sums and consecutive-sample counts.
module tb_adc_permit_mc;

  localparam int unsigned CH       = 2;
  localparam int unsigned W        = 10;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned HOLD     = 3;
  localparam int unsigned RECOVER  = 4;
  localparam int unsigned TIMEOUT  = 100;

  logic            clk = 1'b0;
  logic            sclr;
  logic [W-1:0]    adc;
  logic [0:0]      adc_ch;
  logic            adc_valid;
  logic            adc_err;
  logic [CH*W-1:0] low;
  logic [CH*W-1:0] high;
  logic [W-1:0]    hyst;
  logic [CH-1:0]   fb_ena;
  logic            soft_permit;
  logic            oi;
  logic            fault_clr;
  logic [W-1:0]    flt_adc;
  logic [0:0]      flt_ch;
  logic            flt_valid;
  logic [CH-1:0]   ch_ok;
  logic            permit;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_sum [CH];
  int m_n   [CH];
  int m_cnt [CH];
  int m_age [CH];
  bit m_ok  [CH];
  int m_flt;
  int m_fch;
  bit m_fv;
  bit m_oi;
  bit m_permit;

  adc_permit_mc #(
    .CH       (CH),
    .W        (W),
    .AVG_LOG2 (AVG_LOG2),
    .HOLD     (HOLD),
    .RECOVER  (RECOVER),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .sclr        (sclr),
    .adc         (adc),
    .adc_ch      (adc_ch),
    .adc_valid   (adc_valid),
    .adc_err     (adc_err),
    .low         (low),
    .high        (high),
    .hyst        (hyst),
    .fb_ena      (fb_ena),
    .soft_permit (soft_permit),
    .oi          (oi),
    .fault_clr   (fault_clr),
    .flt_adc     (flt_adc),
    .flt_ch      (flt_ch),
    .flt_valid   (flt_valid),
    .ch_ok       (ch_ok),
    .permit      (permit)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(int f, int i, int margin);
    int lo;
    int hi;
    lo = int'(low[i*W +: W]) + margin;
    hi = int'(high[i*W +: W]) - margin;
    return (f >= lo) && (f <= hi);
  endfunction

  function automatic logic [CH-1:0] exp_ok();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_ok[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_sum[i] = 0;
      m_n[i]   = 0;
      m_cnt[i] = 0;
      m_age[i] = 0;
      m_ok[i]  = 1'b0;
    end
    m_flt    = 0;
    m_fch    = 0;
    m_fv     = 1'b0;
    m_oi     = 1'b0;
    m_permit = 1'b0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit all_ok;
    bit n_fv;
    bit acc;
    int c;
    if (sclr) begin
      model_reset();
      return;
    end
    all_ok = 1'b1;
    for (int i = 0; i < CH; i++) if (fb_ena[i] && !m_ok[i]) all_ok = 1'b0;
    m_permit = soft_permit && !m_oi && all_ok;
    m_oi     = oi || (m_oi && !fault_clr);
    for (int i = 0; i < CH; i++) begin
      acc = adc_valid && !adc_err && (int'(adc_ch) == i);
      if (acc || !fb_ena[i]) m_age[i] = 0;
      else if (m_age[i] < TIMEOUT) m_age[i]++;
      if (adc_err || m_age[i] >= TIMEOUT) begin
        m_ok[i]  = 1'b0;
        m_cnt[i] = 0;
      end else if (m_fv && m_fch == i) begin
        if (m_ok[i]) begin
          if (!in_win(m_flt, i, 0)) begin
            m_cnt[i]++;
            if (m_cnt[i] >= HOLD) begin
              m_ok[i]  = 1'b0;
              m_cnt[i] = 0;
            end
          end else begin
            m_cnt[i] = 0;
          end
        end else begin
          if (in_win(m_flt, i, int'(hyst))) begin
            m_cnt[i]++;
            if (m_cnt[i] >= RECOVER) begin
              m_ok[i]  = 1'b1;
              m_cnt[i] = 0;
            end
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
    end
    n_fv = 1'b0;
    if (adc_valid && int'(adc_ch) < CH) begin
      c = int'(adc_ch);
      if (adc_err) begin
        m_sum[c] = 0;
        m_n[c]   = 0;
      end else begin
        m_sum[c] += int'(adc);
        m_n[c]++;
        if (m_n[c] == (1 << AVG_LOG2)) begin
          m_flt    = m_sum[c] >> AVG_LOG2;
          m_fch    = c;
          n_fv     = 1'b1;
          m_sum[c] = 0;
          m_n[c]   = 0;
        end
      end
    end
    m_fv = n_fv;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic send(int ch, int val);
    adc_ch    = 1'(ch);
    adc       = W'(val);
    adc_valid = 1'b1;
    cyc();
    adc_valid = 1'b0;
  endtask

  task automatic feed(int ch, int val);
    repeat (1 << AVG_LOG2) send(ch, val);
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    idle(2);
    sclr = 1'b0;
    n_checks++;
    if (flt_adc !== '0) $display("FAIL reset_flt_adc: got %h want 000", flt_adc);
    else n_pass++;
    n_checks++;
    if (flt_valid !== 1'b0 || flt_ch !== 1'b0) begin
      $display("FAIL reset_flt_strobe: got valid=%b ch=%b want 0/0", flt_valid, flt_ch);
    end else n_pass++;
    n_checks++;
    if (ch_ok !== 2'b00) $display("FAIL reset_ch_ok: got %b want 00", ch_ok);
    else n_pass++;
    n_checks++;
    if (permit !== 1'b0) $display("FAIL reset_permit: got %b want 0", permit);
    else n_pass++;
  endtask

  task automatic test_averaging();
    send(0, 'h100);
    send(0, 'h101);
    send(0, 'h102);
    send(0, 'h103);
    n_checks++;
    if (flt_valid !== 1'b1 || flt_adc !== 10'h101 || flt_ch !== 1'b0) begin
      $display("FAIL avg_output: got v=%b adc=%h ch=%b want v=1 adc=101 ch=0",
               flt_valid, flt_adc, flt_ch);
    end else n_pass++;
    cyc();
    n_checks++;
    if (flt_valid !== 1'b0) $display("FAIL avg_strobe_width: got %b want 0", flt_valid);
    else n_pass++;
  endtask

  task automatic test_startup();
    sclr = 1'b1;
    cyc();
    sclr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      feed(0, 'h0C0);
      feed(1, 'h0C0);
    end
    n_checks++;
    if (ch_ok !== 2'b01) $display("FAIL startup_ch0_first: got %b want 01", ch_ok);
    else n_pass++;
    cyc();
    n_checks++;
    if (ch_ok !== 2'b11 || permit !== 1'b0) begin
      $display("FAIL startup_ch_ok: got ok=%b permit=%b want ok=11 permit=0", ch_ok, permit);
    end else n_pass++;
    cyc();
    n_checks++;
    if (permit !== 1'b1) $display("FAIL startup_permit: got %b want 1", permit);
    else n_pass++;
  endtask

  task automatic test_debounce();
    feed(0, 'h101);
    feed(0, 'h101);
    feed(0, 'h0C0);
    idle(2);
    n_checks++;
    if (ch_ok[0] !== 1'b1) $display("FAIL debounce_hold: got %b want 1", ch_ok[0]);
    else n_pass++;
    repeat (3) feed(0, 'h101);
    cyc();
    n_checks++;
    if (ch_ok[0] !== 1'b0 || permit !== 1'b1) begin
      $display("FAIL debounce_fault: got ok0=%b permit=%b want 0/1", ch_ok[0], permit);
    end else n_pass++;
    cyc();
    n_checks++;
    if (permit !== 1'b0) $display("FAIL debounce_permit: got %b want 0", permit);
    else n_pass++;
    feed(1, 'h0C0);
  endtask

  task automatic test_hysteresis();
    for (int k = 0; k < 10; k++) begin
      feed(0, 'h082);
      if (k % 3 == 2) feed(1, 'h0C0);
    end
    idle(2);
    n_checks++;
    if (ch_ok !== 2'b10) $display("FAIL hyst_stays_fault: got %b want 10", ch_ok);
    else n_pass++;
    repeat (3) feed(0, 'h0C0);
    idle(2);
    n_checks++;
    if (ch_ok[0] !== 1'b0) $display("FAIL hyst_three_in: got %b want 0", ch_ok[0]);
    else n_pass++;
    feed(0, 'h0C0);
    idle(2);
    n_checks++;
    if (ch_ok[0] !== 1'b1) $display("FAIL hyst_recovered: got %b want 1", ch_ok[0]);
    else n_pass++;
    repeat (3) feed(0, 'h101);
    feed(1, 'h0C0);
    feed(0, 'h0C0);
    feed(0, 'h0C0);
    feed(0, 'h082);
    feed(1, 'h0C0);
    repeat (3) feed(0, 'h0C0);
    idle(2);
    n_checks++;
    if (ch_ok[0] !== 1'b0) $display("FAIL hyst_restart: got %b want 0", ch_ok[0]);
    else n_pass++;
    feed(0, 'h0C0);
    idle(2);
    n_checks++;
    if (ch_ok !== exp_ok() || ch_ok !== 2'b11) begin
      $display("FAIL hyst_restart_ok: got %b want 11", ch_ok);
    end else n_pass++;
  endtask

  task automatic test_faults();
    adc_err = 1'b1;
    cyc();
    adc_err = 1'b0;
    n_checks++;
    if (ch_ok !== 2'b00) $display("FAIL err_all_fault: got %b want 00", ch_ok);
    else n_pass++;
    cyc();
    n_checks++;
    if (permit !== 1'b0) $display("FAIL err_permit: got %b want 0", permit);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      feed(0, 'h0C0);
      feed(1, 'h0C0);
    end
    idle(2);
    n_checks++;
    if (ch_ok !== 2'b11) $display("FAIL err_recover: got %b want 11", ch_ok);
    else n_pass++;
    repeat (28) feed(0, 'h0C0);
    n_checks++;
    if (ch_ok !== 2'b01 || permit !== 1'b0) begin
      $display("FAIL timeout_ch1: got ok=%b permit=%b want 01/0", ch_ok, permit);
    end else n_pass++;
    fb_ena = 2'b01;
    idle(2);
    n_checks++;
    if (permit !== 1'b1) $display("FAIL mask_permit: got %b want 1", permit);
    else n_pass++;
  endtask

  task automatic test_oi();
    feed(0, 'h0C0);
    oi = 1'b1;
    cyc();
    oi = 1'b0;
    cyc();
    n_checks++;
    if (permit !== 1'b0) $display("FAIL oi_drop: got %b want 0", permit);
    else n_pass++;
    oi        = 1'b1;
    fault_clr = 1'b1;
    cyc();
    oi        = 1'b0;
    fault_clr = 1'b0;
    idle(2);
    n_checks++;
    if (permit !== 1'b0) $display("FAIL oi_clr_blocked: got %b want 0", permit);
    else n_pass++;
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    cyc();
    n_checks++;
    if (permit !== 1'b1) $display("FAIL oi_cleared: got %b want 1", permit);
    else n_pass++;
  endtask

  task automatic test_sclr_mid();
    send(0, 'h3FF);
    send(0, 'h3FF);
    sclr = 1'b1;
    cyc();
    sclr = 1'b0;
    n_checks++;
    if (flt_adc !== '0 || flt_valid !== 1'b0 || ch_ok !== 2'b00 || permit !== 1'b0) begin
      $display("FAIL sclr_outputs: got adc=%h v=%b ok=%b permit=%b want all 0",
               flt_adc, flt_valid, ch_ok, permit);
    end else n_pass++;
    send(0, 'h010);
    send(0, 'h020);
    send(0, 'h030);
    send(0, 'h040);
    n_checks++;
    if (flt_valid !== 1'b1 || flt_adc !== 10'h028 || flt_ch !== 1'b0) begin
      $display("FAIL sclr_fresh_avg: got v=%b adc=%h ch=%b want 1/028/0",
               flt_valid, flt_adc, flt_ch);
    end else n_pass++;
  endtask

  task automatic test_random();
    int bases [5];
    int base  [CH];
    int val;
    bases   = '{'h0C0, 'h082, 'h101, 'h07F, 'h0F9};
    base[0] = 'h0C0;
    base[1] = 'h0C0;
    fb_ena  = 2'b11;
    sclr    = 1'b1;
    cyc();
    sclr = 1'b0;
    for (int t = 0; t < 1200; t++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 39) == 0) base[i] = bases[$urandom_range(0, 4)];
      end
      // Second half: channel 1 gets an inverted window, so it can never be healthy.
      if (t == 600) begin
        low[W +: W]  = 10'h100;
        high[W +: W] = 10'h080;
      end
      adc_ch      = 1'($urandom_range(0, 1));
      val         = base[int'(adc_ch)] + int'($urandom_range(0, 4)) - 2;
      adc         = W'(val);
      adc_valid   = ($urandom_range(0, 1) == 1);
      adc_err     = ($urandom_range(0, 299) == 0);
      oi          = ($urandom_range(0, 399) == 0);
      fault_clr   = ($urandom_range(0, 29) == 0);
      soft_permit = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 149) == 0) fb_ena = 2'($urandom_range(0, 3));
      cyc();
      n_checks++;
      if (ch_ok !== exp_ok()) begin
        $display("FAIL rand_ch_ok t=%0d: got %b want %b", t, ch_ok, exp_ok());
      end else n_pass++;
      n_checks++;
      if (permit !== m_permit) begin
        $display("FAIL rand_permit t=%0d: got %b want %b", t, permit, m_permit);
      end else n_pass++;
      n_checks++;
      if (flt_valid !== m_fv || flt_adc !== W'(m_flt) || flt_ch !== 1'(m_fch)) begin
        $display("FAIL rand_filter t=%0d: got v=%b adc=%h ch=%b want v=%b adc=%h ch=%0d",
                 t, flt_valid, flt_adc, flt_ch, m_fv, W'(m_flt), m_fch);
      end else n_pass++;
    end
    adc_valid   = 1'b0;
    adc_err     = 1'b0;
    oi          = 1'b0;
    fault_clr   = 1'b0;
    soft_permit = 1'b1;
  endtask

  initial begin
    sclr        = 1'b1;
    adc         = '0;
    adc_ch      = '0;
    adc_valid   = 1'b0;
    adc_err     = 1'b0;
    low         = {10'h080, 10'h080};
    high        = {10'h100, 10'h100};
    hyst        = 10'h008;
    fb_ena      = 2'b11;
    soft_permit = 1'b1;
    oi          = 1'b0;
    fault_clr   = 1'b0;
    model_reset();

    test_reset();
    test_averaging();
    test_startup();
    test_debounce();
    test_hysteresis();
    test_faults();
    test_oi();
    test_sclr_mid();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
